sweep_peak_ctrl: RTL and testbench

SWEEP_PEAK_CTRL -- requirements
Module: sweep_peak_ctrl

---
 rtl/sweep_pkg.sv | 23 ++
 rtl/avg_acc.sv | 45 ++++
 rtl/sweep_peak_ctrl.sv | 162 ++++++++++++++++
 tb/tb_sweep_peak_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sweep_pkg
// Description : Shared state encoding and default widths for the sweep
//               peak controller.
// Revision    : 1.0 - initial release
// ============================================================================
package sweep_pkg;

    localparam int unsigned c_fw_default = 16;
    localparam int unsigned c_aw_default = 12;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_ACQ    = 3'd3,
        S_EVAL   = 3'd4,
        S_FIN    = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/avg_acc.sv
`default_nettype none
// ============================================================================
// Module      : avg_acc
// Description : Sums 2^NAVG_LOG2 samples; cnt_done flags the final sample.
// Revision    : 1.0 - initial release
// ============================================================================
module avg_acc
    import sweep_pkg::*;
#(
    parameter int unsigned AW        = c_aw_default,
    parameter int unsigned NAVG_LOG2 = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic [AW-1:0]           din,
    output logic [AW+NAVG_LOG2-1:0] sum,
    output logic                    cnt_done
);

    localparam int unsigned c_sw   = AW + NAVG_LOG2;
    localparam int unsigned c_cw   = NAVG_LOG2 + 1;
    localparam int unsigned c_last = (1 << NAVG_LOG2) - 1;

    logic [c_cw-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum   <= '0;
            r_cnt <= '0;
        end else if (clr) begin
            sum   <= '0;
            r_cnt <= '0;
        end else if (en) begin
            sum   <= sum + c_sw'(din);
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Asserted in the same cycle as the last accepted sample
    assign cnt_done = en && (r_cnt == c_cw'(c_last));

endmodule
`default_nettype wire

// File: rtl/sweep_peak_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sweep_peak_ctrl
// Description : Steps a frequency code across a range, averages the ADC
//               magnitude at each point and tracks the peak.
// Revision    : 1.0 - initial release
// ============================================================================
module sweep_peak_ctrl
    import sweep_pkg::*;
#(
    parameter int unsigned FW        = c_fw_default,
    parameter int unsigned AW        = c_aw_default,
    parameter int unsigned SETTLE    = 64,
    parameter int unsigned NAVG_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [FW-1:0] f_start,
    input  logic [FW-1:0] f_stop,
    input  logic [FW-1:0] f_step,
    input  logic          adc_valid,
    input  logic [AW-1:0] adc_data,
    output logic [FW-1:0] freq_code,
    output logic          freq_load,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [FW-1:0] peak_code,
    output logic [AW-1:0] peak_mag
);

    localparam logic [15:0] c_settle_last = 16'(SETTLE - 1);

    state_t                  r_state;
    logic [FW-1:0]           r_cur;
    logic [FW-1:0]           r_stop;
    logic [FW-1:0]           r_step;
    logic [15:0]             r_settle;
    logic                    r_first;

    logic                    w_acc_clr;
    logic                    w_acc_en;
    logic [AW+NAVG_LOG2-1:0] w_sum;
    logic                    w_cnt_done;
    logic [AW-1:0]           w_avg;
    logic [FW:0]             w_next;
    logic                    w_active;
    logic                    w_bounds_ok;

    assign w_acc_clr   = (r_state == S_LOAD);
    assign w_acc_en    = (r_state == S_ACQ) && adc_valid;
    assign w_avg       = AW'(w_sum >> NAVG_LOG2);
    assign w_next      = {1'b0, r_cur} + {1'b0, r_step};
    assign w_active    = (r_state != S_IDLE) && (r_state != S_FIN);
    assign w_bounds_ok = (f_step != '0) && (f_start <= f_stop);

    avg_acc #(
        .AW        (AW),
        .NAVG_LOG2 (NAVG_LOG2)
    ) u_avg_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (w_acc_clr),
        .en       (w_acc_en),
        .din      (adc_data),
        .sum      (w_sum),
        .cnt_done (w_cnt_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cur     <= '0;
            r_stop    <= '0;
            r_step    <= '0;
            r_settle  <= '0;
            r_first   <= 1'b0;
            freq_code <= '0;
            freq_load <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            peak_code <= '0;
            peak_mag  <= '0;
        end else begin
            freq_load <= 1'b0;
            done      <= 1'b0;
            if (w_active && abort) begin
                r_state <= S_FIN;
                err     <= 1'b1;
                busy    <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_bounds_ok) begin
                                r_cur     <= f_start;
                                r_stop    <= f_stop;
                                r_step    <= f_step;
                                r_first   <= 1'b1;
                                err       <= 1'b0;
                                peak_code <= '0;
                                peak_mag  <= '0;
                                busy      <= 1'b1;
                                r_state   <= S_LOAD;
                            end else begin
                                err     <= 1'b1;
                                r_state <= S_FIN;
                            end
                        end
                    end
                    S_LOAD: begin
                        freq_code <= r_cur;
                        freq_load <= 1'b1;
                        r_settle  <= '0;
                        r_state   <= S_SETTLE;
                    end
                    S_SETTLE: begin
                        if (r_settle == c_settle_last) begin
                            r_state <= S_ACQ;
                        end else begin
                            r_settle <= r_settle + 16'd1;
                        end
                    end
                    S_ACQ: begin
                        if (w_cnt_done) begin
                            r_state <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        // Strict compare on an ascending sweep keeps the lowest code on ties
                        if (r_first || (w_avg > peak_mag)) begin
                            peak_mag  <= w_avg;
                            peak_code <= r_cur;
                        end
                        r_first <= 1'b0;
                        if (w_next[FW] || (w_next > {1'b0, r_stop})) begin
                            busy    <= 1'b0;
                            r_state <= S_FIN;
                        end else begin
                            r_cur   <= w_next[FW-1:0];
                            r_state <= S_LOAD;
                        end
                    end
                    S_FIN: begin
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sweep_peak_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_sweep_peak_ctrl
// Description : Self-checking bench: directed table, corner sequences and
//               randomized sweeps against a behavioural peak model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sweep_peak_ctrl;

    localparam int FW     = 16;
    localparam int AW     = 12;
    localparam int SETTLE = 4;
    localparam int NAVG   = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [FW-1:0] f_start = '0;
    logic [FW-1:0] f_stop = '0;
    logic [FW-1:0] f_step = '0;
    logic          adc_valid = 1'b0;
    logic [AW-1:0] adc_data = '0;
    logic [FW-1:0] freq_code;
    logic          freq_load;
    logic          busy;
    logic          done;
    logic          err;
    logic [FW-1:0] peak_code;
    logic [AW-1:0] peak_mag;

    sweep_peak_ctrl #(
        .FW        (FW),
        .AW        (AW),
        .SETTLE    (SETTLE),
        .NAVG_LOG2 (NAVG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .f_start   (f_start),
        .f_stop    (f_stop),
        .f_step    (f_step),
        .adc_valid (adc_valid),
        .adc_data  (adc_data),
        .freq_code (freq_code),
        .freq_load (freq_load),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .peak_code (peak_code),
        .peak_mag  (peak_mag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // 0: ADC answers with the magnitude table at random strobes, 1: manual, 2: silent
    int            adc_mode = 0;
    logic [AW-1:0] mag_mem [256];

    logic [FW-1:0] got_codes [$];
    logic [FW-1:0] exp_codes [$];
    int            nl_g, first_load_g, done_cyc_g;
    bit            gd_g, busy_load_g;

    always @(negedge clk) begin
        if (adc_mode == 0) begin
            adc_valid = ($urandom_range(0, 1) == 1);
            adc_data  = mag_mem[freq_code[7:0]];
        end else if (adc_mode == 2) begin
            adc_valid = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic bit codes_match();
        if (got_codes.size() != exp_codes.size()) return 1'b0;
        foreach (exp_codes[k]) if (got_codes[k] !== exp_codes[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Reference: visit every code fs, fs+st, ... <= fe; first visit or strictly larger wins
    task automatic model_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                               input logic [FW-1:0] st, output int n,
                               output logic [FW-1:0] pc, output logic [AW-1:0] pm,
                               output logic e);
        exp_codes.delete();
        n = 0; pc = '0; pm = '0; e = 1'b0;
        if (st == 0 || fs > fe) begin
            e = 1'b1;
            return;
        end
        for (int c = int'(fs); c <= int'(fe); c += int'(st)) begin
            exp_codes.push_back(FW'(c));
            n++;
            if (n == 1 || mag_mem[c[7:0]] > pm) begin
                pm = mag_mem[c[7:0]];
                pc = FW'(c);
            end
        end
    endtask

    task automatic run_sweep(input logic [FW-1:0] fs, input logic [FW-1:0] fe,
                             input logic [FW-1:0] st, input int abort_at, input bit restart);
        int last_load;
        got_codes.delete();
        nl_g = 0; gd_g = 0; first_load_g = 0; done_cyc_g = 0; busy_load_g = 0;
        last_load = 0;
        @(negedge clk);
        f_start = fs; f_stop = fe; f_step = st; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 20000; i++) begin
            start = 1'b0;
            abort = 1'b0;
            if (freq_load) begin
                nl_g++;
                last_load = i;
                got_codes.push_back(freq_code);
                if (nl_g == 1) begin
                    first_load_g = i;
                    busy_load_g  = busy;
                end
            end
            if (restart && nl_g == 1 && i == first_load_g + 2) begin
                f_start = 16'd0; f_stop = 16'd1; f_step = 16'd1; start = 1'b1;
            end
            if (abort_at > 0 && nl_g == abort_at && i == last_load + 1) abort = 1'b1;
            if (done) begin
                gd_g = 1;
                done_cyc_g = i;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        abort = 1'b0;
    endtask

    typedef struct {
        logic [FW-1:0] fs, fe, st;
        int            nl;
        logic [FW-1:0] pc;
        logic [AW-1:0] pm;
        bit            chk_peak;
        logic          e;
    } vec_t;

    initial begin
        vec_t          vt [6];
        int            mn;
        logic [FW-1:0] mpc;
        logic [AW-1:0] mpm;
        logic          me;
        int            nd;
        bit            seen;

        vt[0] = '{16'd10, 16'd14, 16'd1, 5, 16'd12, 12'd900, 1'b1, 1'b0};
        vt[1] = '{16'd20, 16'd30, 16'd10, 2, 16'd20, 12'd500, 1'b1, 1'b0};
        vt[2] = '{16'hFFF0, 16'hFFFF, 16'h0020, 1, 16'hFFF0, 12'd777, 1'b1, 1'b0};
        vt[3] = '{16'd50, 16'd50, 16'd3, 1, 16'd50, 12'd42, 1'b1, 1'b0};
        vt[4] = '{16'd10, 16'd14, 16'd0, 0, 16'd0, 12'd0, 1'b0, 1'b1};
        vt[5] = '{16'd60, 16'd40, 16'd1, 0, 16'd0, 12'd0, 1'b0, 1'b1};

        for (int k = 0; k < 256; k++) mag_mem[k] = 12'd7;
        mag_mem[10] = 12'd100; mag_mem[11] = 12'd300; mag_mem[12] = 12'd900;
        mag_mem[13] = 12'd300; mag_mem[14] = 12'd100;
        mag_mem[20] = 12'd500; mag_mem[30] = 12'd500;
        mag_mem[8'hF0] = 12'd777; mag_mem[50] = 12'd42;

        repeat (3) @(negedge clk);
        check("reset_outputs", {freq_code, freq_load, busy, done, err, peak_code, peak_mag}, 64'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            run_sweep(vt[v].fs, vt[v].fe, vt[v].st, 0, 1'b0);
            model_sweep(vt[v].fs, vt[v].fe, vt[v].st, mn, mpc, mpm, me);
            check($sformatf("vec%0d_done", v), gd_g, 1);
            check($sformatf("vec%0d_loads", v), nl_g, vt[v].nl);
            check($sformatf("vec%0d_err", v), err, vt[v].e);
            check($sformatf("vec%0d_codes", v), codes_match(), 1);
            if (vt[v].chk_peak) begin
                check($sformatf("vec%0d_peak_code", v), peak_code, vt[v].pc);
                check($sformatf("vec%0d_peak_mag", v), peak_mag, vt[v].pm);
                check($sformatf("vec%0d_latency", v), first_load_g, 2);
                check($sformatf("vec%0d_busy_in_sweep", v), busy_load_g, 1);
            end else begin
                check($sformatf("vec%0d_err_done_cyc", v), (done_cyc_g >= 1 && done_cyc_g <= 2), 1);
            end
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", v), {busy, done}, 2'b00);
        end

        // Abort in the third settle window: points 10 and 11 only
        run_sweep(16'd10, 16'd14, 16'd1, 3, 1'b0);
        check("abort_done", gd_g, 1);
        check("abort_loads", nl_g, 3);
        check("abort_err", err, 1);
        check("abort_peak_code", peak_code, 16'd11);
        check("abort_peak_mag", peak_mag, 12'd300);

        // A second start mid-sweep must not disturb the running sweep
        run_sweep(16'd10, 16'd14, 16'd1, 0, 1'b1);
        check("restart_loads", nl_g, 5);
        check("restart_peak", {peak_code, peak_mag}, {16'd12, 12'd900});
        check("restart_err", err, 0);

        // Averaging 1,2,3,5 -> 2; full-scale samples during settle must be ignored
        adc_mode = 1;
        adc_valid = 1'b0;
        @(negedge clk);
        f_start = 16'd5; f_stop = 16'd5; f_step = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (freq_load) seen = 1;
            else @(negedge clk);
        end
        check("avg_load_seen", seen, 1);
        adc_valid = 1'b1; adc_data = 12'd4095;
        repeat (SETTLE) @(negedge clk);
        adc_data = 12'd1; @(negedge clk);
        adc_data = 12'd2; @(negedge clk);
        adc_data = 12'd3; @(negedge clk);
        adc_data = 12'd5; @(negedge clk);
        adc_valid = 1'b0; adc_data = 12'd4095;
        seen = 0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (done) seen = 1;
            else @(negedge clk);
        end
        check("avg_done", seen, 1);
        check("avg_peak", {peak_code, peak_mag}, {16'd5, 12'd2});

        // Reset while acquiring
        adc_mode = 2;
        @(negedge clk);
        f_start = 16'd10; f_stop = 16'd14; f_step = 16'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (freq_load) seen = 1;
            else @(negedge clk);
        end
        repeat (SETTLE + 2) @(negedge clk);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("rst_async_outputs", {freq_code, freq_load, busy, done, err, peak_code, peak_mag}, 64'd0);
        nd = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done) nd++;
            @(negedge clk);
        end
        check("rst_no_done", nd, 0);
        adc_mode = 0;
        run_sweep(16'd20, 16'd30, 16'd10, 0, 1'b0);
        check("post_rst_accepted", {gd_g, 8'(nl_g), peak_code}, {1'b1, 8'd2, 16'd20});

        // Randomized sweeps against the model
        for (int r = 0; r < 20; r++) begin
            logic [FW-1:0] fs, fe, st;
            int sel;
            for (int k = 0; k < 256; k++) mag_mem[k] = AW'($urandom_range(0, 20) * 100);
            sel = $urandom_range(0, 7);
            fs = FW'($urandom_range(0, 150));
            fe = fs + FW'($urandom_range(0, 40));
            st = FW'($urandom_range(1, 12));
            if (sel == 0) st = 16'd0;
            else if (sel == 1) begin
                fs = FW'($urandom_range(50, 200));
                fe = fs - FW'($urandom_range(1, 50));
            end else if (sel == 2) begin
                fs = 16'hFF00 + FW'($urandom_range(0, 200));
                fe = 16'hFFFF;
                st = FW'($urandom_range(8, 300));
            end
            model_sweep(fs, fe, st, mn, mpc, mpm, me);
            run_sweep(fs, fe, st, 0, 1'b0);
            check($sformatf("rnd%0d_done", r), gd_g, 1);
            check($sformatf("rnd%0d_loads", r), nl_g, mn);
            check($sformatf("rnd%0d_err", r), err, me);
            check($sformatf("rnd%0d_codes", r), codes_match(), 1);
            if (!me) check($sformatf("rnd%0d_peak", r), {peak_code, peak_mag}, {mpc, mpm});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
